uart_tx_arbiter: RTL and testbench
==================================

UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 16; maximum cycles to wait for tx_busy rise after a tx_start pulse.
REQ-002 clk  input  1  system clock, 10 MHz, rising-edge active.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 req0_valid  input  1  requester 0 has a byte pending.
REQ-005 req0_data  input  8  requester 0 byte; stable while req0_valid is high.
REQ-006 req0_ready  output  1  requester 0 byte accepted this cycle.
REQ-007 req1_valid  input  1  requester 1 has a byte pending.
REQ-008 req1_data  input  8  requester 1 byte; stable while req1_valid is high.
REQ-009 req1_ready  output  1  requester 1 byte accepted this cycle.
REQ-010 tx_start  output  1  one-cycle start pulse to the UART transmitter.
REQ-011 tx_data  output  8  byte to the UART transmitter; held from the start pulse until the return to IDLE.
REQ-012 tx_busy  input  1  transmitter busy flag.
REQ-013 grant_id  output  1  requester owning the current or most recent transfer.
REQ-014 timeout_err  output  1  one-cycle pulse on a start-handshake timeout.

Function
REQ-015 FSM states SHALL be IDLE, START, WAIT_BUSY and WAIT_DONE.
REQ-016 IDLE: when tx_busy=0 and at least one valid is high, the block SHALL raise ready combinationally for exactly one winner; the transfer is valid&&ready.
REQ-017 Arbitration SHALL be round-robin: only one valid -> that requester wins; both valid -> the requester not served last wins.
REQ-018 On transfer in cycle N: latch the winner's data into tx_data, set grant_id, update last_served, go to START.
REQ-019 START (cycle N+1): tx_start=1 for exactly this cycle, then go to WAIT_BUSY.
REQ-020 WAIT_BUSY: tx_start=0; on tx_busy=1 go to WAIT_DONE.
REQ-021 WAIT_DONE: on tx_busy=0 go to IDLE; a new grant is possible in that same IDLE cycle.
REQ-022 Neither ready SHALL assert outside IDLE, or in IDLE while tx_busy=1.
REQ-023 A requester that drops valid before being granted SHALL simply lose the slot; no byte is recorded.
REQ-024 Each accepted byte SHALL produce exactly one tx_start; no byte is dropped or duplicated.
REQ-025 Latency SHALL be one cycle from transfer (ready high) to tx_start.

Reset
REQ-026 While rst_n=0: state=IDLE, tx_start=0, tx_data=0, grant_id=0, timeout_err=0, last_served=1, and the timeout counter is cleared.
REQ-027 The reset values of last_served and grant_id SHALL make requester 0 win the first tie.
REQ-028 Reset asserted mid-transfer SHALL abort immediately; after release the block SHALL start in IDLE with no pending state.

Configuration
REQ-029 Macro UART_ARB_TIMEOUT_EN defined: an 8-bit counter runs in WAIT_BUSY.
REQ-030 Macro UART_ARB_TIMEOUT_EN defined: if tx_busy is still 0 after TIMEOUT_CYCLES cycles, pulse timeout_err for one cycle and go to IDLE; the byte is discarded.
REQ-031 Macro UART_ARB_TIMEOUT_EN undefined: WAIT_BUSY waits indefinitely; timeout_err is tied to 0 and no counter logic is present.

Structure
REQ-032 Shared package uart_pkg SHALL hold: FSM state encoding, CLK_FREQ=10000000, BAUD_RATE=115200, BIT_PERIOD=CLK_FREQ/BAUD_RATE (86), and the default TIMEOUT_CYCLES.
REQ-033 Two-way round-robin grant logic SHALL live in sub-module uart_rr_arb2 (inputs: valids, last_served, enable; outputs: one-hot grant).
REQ-034 The FSM and the datapath SHALL remain in uart_tx_arbiter.

Verification
REQ-035 After reset, req0_valid=1 with data 0x55 -> req0_ready high 1 cycle, tx_start next cycle, tx_data=0x55, grant_id=0, and the serial line shows 0x55 at 86 cycles/bit.
REQ-036 Both valid continuously (req0 data 0xA0, req1 data 0xB1), 4 bytes -> tx_data sequence 0xA0, 0xB1, 0xA0, 0xB1 and grant_id alternates 0,1,0,1.
REQ-037 req1_valid raised while a req0 byte is transmitting -> req1_ready stays 0 until tx_busy falls, then asserts in the IDLE cycle.
REQ-038 With UART_ARB_TIMEOUT_EN and tx_busy forced 0 -> timeout_err pulses 16 cycles after tx_start, the block returns to IDLE, and the next byte is accepted; without the macro, the FSM stays in WAIT_BUSY.
REQ-039 rst_n pulsed low during WAIT_DONE -> all outputs take reset values asynchronously; after release, a tie is granted to requester 0.
REQ-040 Across a random valid stream of 200 bytes per requester -> tx_start count equals the handshake count, and the transmitted bytes match the scoreboard in order per requester.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit arbiter: FSM state encoding,
// serial timing constants and the default start-handshake timeout.
package uart_pkg;

    typedef logic [1:0] state_t;

    localparam logic [1:0] ST_IDLE      = 2'd0;
    localparam logic [1:0] ST_START     = 2'd1;
    localparam logic [1:0] ST_WAIT_BUSY = 2'd2;
    localparam logic [1:0] ST_WAIT_DONE = 2'd3;

    localparam int CLK_FREQ   = 10_000_000;
    localparam int BAUD_RATE  = 115_200;
    localparam int BIT_PERIOD = CLK_FREQ / BAUD_RATE;

    localparam int DEFAULT_TIMEOUT_CYCLES = 16;

endpackage

// File: rtl/uart_rr_arb2.sv
// Two-way round-robin grant: a lone requester always wins, and on a tie the
// requester that was not served last wins.
module uart_rr_arb2
    import uart_pkg::*;
(
    input  logic [1:0] valid_i,
    input  logic       last_served_i,
    input  logic       enable_i,
    output logic [1:0] grant_o
);

    always_comb begin
        grant_o = 2'b00;
        if (enable_i) begin
            if (valid_i == 2'b11) begin
                grant_o = last_served_i ? 2'b01 : 2'b10;
            end else begin
                grant_o = valid_i;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Two requesters share one UART transmitter through a round-robin grant and a
// start/busy handshake FSM. Define UART_ARB_TIMEOUT_EN to abort unacknowledged starts.
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req0_valid,
    input  logic [7:0] req0_data,
    output logic       req0_ready,
    input  logic       req1_valid,
    input  logic [7:0] req1_data,
    output logic       req1_ready,
    output logic       tx_start,
    output logic [7:0] tx_data,
    input  logic       tx_busy,
    output logic       grant_id,
    output logic       timeout_err
);

    state_t     state_q, state_d;
    logic [7:0] tx_data_q, tx_data_d;
    logic       grant_id_q, grant_id_d;
    logic       last_served_q, last_served_d;
    logic [1:0] grant;
    logic       arb_enable;
    logic       timeout_hit;

    if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
        $error("uart_tx_arbiter: TIMEOUT_CYCLES must be within 2..255");
    end

    assign arb_enable = (state_q == ST_IDLE) && !tx_busy;

    uart_rr_arb2 u_rr_arb (
        .valid_i       ({req1_valid, req0_valid}),
        .last_served_i (last_served_q),
        .enable_i      (arb_enable),
        .grant_o       (grant)
    );

    assign req0_ready = grant[0];
    assign req1_ready = grant[1];

`ifdef UART_ARB_TIMEOUT_EN
    localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CYCLES - 1);

    logic [7:0] timeout_cnt_q, timeout_cnt_d;
    logic       timeout_err_q;

    // Counts cycles since the start pulse, so it expires TIMEOUT_CYCLES after tx_start.
    always_comb begin
        timeout_cnt_d = timeout_cnt_q;
        if (state_q == ST_IDLE) begin
            timeout_cnt_d = 8'd0;
        end else if (timeout_cnt_q != 8'hFF) begin
            timeout_cnt_d = timeout_cnt_q + 8'd1;
        end
    end

    assign timeout_hit = (state_q == ST_WAIT_BUSY) && !tx_busy
                         && (timeout_cnt_q == TIMEOUT_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            timeout_cnt_q <= 8'd0;
            timeout_err_q <= 1'b0;
        end else begin
            timeout_cnt_q <= timeout_cnt_d;
            timeout_err_q <= timeout_hit;
        end
    end

    assign timeout_err = timeout_err_q;
`else
    assign timeout_hit = 1'b0;
    assign timeout_err = 1'b0;
`endif

    always_comb begin
        state_d       = state_q;
        tx_data_d     = tx_data_q;
        grant_id_d    = grant_id_q;
        last_served_d = last_served_q;
        case (state_q)
            ST_IDLE: begin
                if (grant != 2'b00) begin
                    tx_data_d     = grant[1] ? req1_data : req0_data;
                    grant_id_d    = grant[1];
                    last_served_d = grant[1];
                    state_d       = ST_START;
                end
            end
            ST_START: state_d = ST_WAIT_BUSY;
            ST_WAIT_BUSY: begin
                if (tx_busy) begin
                    state_d = ST_WAIT_DONE;
                end else if (timeout_hit) begin
                    state_d = ST_IDLE;
                end
            end
            ST_WAIT_DONE: begin
                if (!tx_busy) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // last_served resets to 1 so requester 0 wins the first tie.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            tx_data_q     <= 8'h00;
            grant_id_q    <= 1'b0;
            last_served_q <= 1'b1;
        end else begin
            state_q       <= state_d;
            tx_data_q     <= tx_data_d;
            grant_id_q    <= grant_id_d;
            last_served_q <= last_served_d;
        end
    end

    assign tx_start = (state_q == ST_START);
    assign tx_data  = tx_data_q;
    assign grant_id = grant_id_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter with a behavioural UART transmitter model;
// timeout steps follow UART_ARB_TIMEOUT_EN.
`timescale 1ns/1ps
module tb_uart_tx_arbiter;
    import uart_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       req0_valid = 1'b0;
    logic [7:0] req0_data = 8'h00;
    logic       req0_ready;
    logic       req1_valid = 1'b0;
    logic [7:0] req1_data = 8'h00;
    logic       req1_ready;
    logic       tx_start;
    logic [7:0] tx_data;
    logic       tx_busy;
    logic       grant_id;
    logic       timeout_err;

    int         errors = 0;
    int         checks = 0;
    int         bitPeriod = 2;
    logic       forceBusyLow = 1'b0;
    logic [9:0] frame;
    int         bitIdx;
    int         cycIdx;
    logic       serialLine;

    uart_tx_arbiter dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req0_valid  (req0_valid),
        .req0_data   (req0_data),
        .req0_ready  (req0_ready),
        .req1_valid  (req1_valid),
        .req1_data   (req1_data),
        .req1_ready  (req1_ready),
        .tx_start    (tx_start),
        .tx_data     (tx_data),
        .tx_busy     (tx_busy),
        .grant_id    (grant_id),
        .timeout_err (timeout_err)
    );

    always #50 clk = ~clk;

    // Transmitter model: start bit, 8 data bits LSB first, stop bit, bitPeriod cycles each.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_busy    <= 1'b0;
            serialLine <= 1'b1;
            frame      <= '0;
            bitIdx     <= 0;
            cycIdx     <= 0;
        end else if (tx_busy) begin
            if (cycIdx == bitPeriod - 1) begin
                cycIdx <= 0;
                if (bitIdx == 9) begin
                    tx_busy    <= 1'b0;
                    serialLine <= 1'b1;
                end else begin
                    bitIdx     <= bitIdx + 1;
                    serialLine <= frame[bitIdx + 1];
                end
            end else begin
                cycIdx <= cycIdx + 1;
            end
        end else if (tx_start && !forceBusyLow) begin
            tx_busy    <= 1'b1;
            frame      <= {1'b1, tx_data, 1'b0};
            serialLine <= 1'b0;
            bitIdx     <= 0;
            cycIdx     <= 0;
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic v0, input logic [7:0] d0,
                                 input logic v1, input logic [7:0] d1);
        req0_valid = v0;
        req0_data  = d0;
        req1_valid = v1;
        req1_data  = d1;
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    task automatic doReset();
        applyStimulus(1'b0, 8'h00, 1'b0, 8'h00);
        rst_n = 1'b0;
        tick(2);
        checkOutput("rst_tx_start", tx_start, 0);
        checkOutput("rst_tx_data", tx_data, 0);
        checkOutput("rst_grant", grant_id, 0);
        checkOutput("rst_timeout", timeout_err, 0);
        rst_n = 1'b1;
        tick();
    endtask

    task automatic waitGrant(input int limit, output logic found);
        found = 1'b0;
        for (int c = 0; c < limit; c++) begin
            if (req0_ready || req1_ready) begin
                found = 1'b1;
                break;
            end
            tick();
        end
    endtask

    initial begin
        logic       found;
        logic       sawFlag;
        logic [7:0] rxByte;
        logic [8:0] qAll[$];
        logic [8:0] item;
        logic       v0, v1;
        logic [7:0] d0, d1;
        int         sent0, sent1, starts;

        $display("[TB] starting uart_tx_arbiter bench");

        // Single requester, full-rate serial frame of 0x55
        doReset();
        bitPeriod = BIT_PERIOD;
        applyStimulus(1'b1, 8'h55, 1'b0, 8'h00);
        checkOutput("single_rdy", {req1_ready, req0_ready}, 2'b01);
        tick();
        applyStimulus(1'b0, 8'h00, 1'b0, 8'h00);
        checkOutput("single_start", tx_start, 1);
        checkOutput("single_data", tx_data, 8'h55);
        checkOutput("single_grant", grant_id, 0);
        checkOutput("single_rdy_off", req0_ready, 0);
        tick(1 + BIT_PERIOD / 2);
        checkOutput("ser_start_bit", serialLine, 0);
        rxByte = 8'h00;
        for (int b = 0; b < 8; b++) begin
            tick(BIT_PERIOD);
            rxByte[b] = serialLine;
        end
        checkOutput("ser_byte", rxByte, 8'h55);
        tick(BIT_PERIOD);
        checkOutput("ser_stop_bit", serialLine, 1);
        checkOutput("single_data_held", tx_data, 8'h55);
        checkOutput("single_no_restart", tx_start, 0);
        sawFlag = 1'b0;
        for (int c = 0; c < 200; c++) begin
            if (!tx_busy) begin
                sawFlag = 1'b1;
                break;
            end
            tick();
        end
        checkOutput("single_busy_fell", sawFlag, 1);

        // Both requesters continuously valid: alternation starting with 0
        doReset();
        bitPeriod = 2;
        applyStimulus(1'b1, 8'hA0, 1'b1, 8'hB1);
        for (int i = 0; i < 4; i++) begin
            waitGrant(200, found);
            checkOutput("rr_found", found, 1);
            if (found) begin
                checkOutput("rr_ready", {req1_ready, req0_ready}, (i % 2) ? 2'b10 : 2'b01);
                tick();
                checkOutput("rr_start", tx_start, 1);
                checkOutput("rr_data", tx_data, (i % 2) ? 8'hB1 : 8'hA0);
                checkOutput("rr_grant", grant_id, i % 2);
            end
        end

        // Late requester 1 must wait until the transmitter goes idle
        doReset();
        applyStimulus(1'b1, 8'h3C, 1'b0, 8'h00);
        checkOutput("late_rdy0", req0_ready, 1);
        tick();
        applyStimulus(1'b0, 8'h00, 1'b1, 8'h7E);
        checkOutput("late_start", tx_start, 1);
        checkOutput("late_data", tx_data, 8'h3C);
        checkOutput("late_rdy1_start", req1_ready, 0);
        sawFlag = 1'b0;
        found = 1'b0;
        for (int c = 0; c < 100; c++) begin
            tick();
            if (!tx_busy) begin
                found = 1'b1;
                break;
            end
            sawFlag |= req1_ready;
        end
        checkOutput("late_busy_fell", found, 1);
        checkOutput("late_rdy1_busy", sawFlag, 0);
        checkOutput("late_rdy1_wait_done", req1_ready, 0);
        tick();
        checkOutput("late_rdy1_idle", req1_ready, 1);
        tick();
        applyStimulus(1'b0, 8'h00, 1'b0, 8'h00);
        checkOutput("late_start1", tx_start, 1);
        checkOutput("late_data1", tx_data, 8'h7E);
        checkOutput("late_grant1", grant_id, 1);

        // Random valid stream, 200 bytes per requester, fast transmitter
        doReset();
        bitPeriod = 1;
        v0 = 1'b0; v1 = 1'b0; d0 = 8'h00; d1 = 8'h00;
        sent0 = 0; sent1 = 0; starts = 0;
        sawFlag = 1'b0;
        for (int cyc = 0; cyc < 40000; cyc++) begin
            if (sent0 == 200 && sent1 == 200 && qAll.size() == 0) break;
            if (!v0) begin
                if (sent0 < 200 && $urandom_range(0, 2) != 0) begin
                    v0 = 1'b1;
                    d0 = 8'($urandom_range(0, 255));
                end
            end else if ($urandom_range(0, 15) == 0) begin
                v0 = 1'b0;
            end
            if (!v1) begin
                if (sent1 < 200 && $urandom_range(0, 2) != 0) begin
                    v1 = 1'b1;
                    d1 = 8'($urandom_range(0, 255));
                end
            end else if ($urandom_range(0, 15) == 0) begin
                v1 = 1'b0;
            end
            applyStimulus(v0, d0, v1, d1);
            sawFlag |= (req0_ready && req1_ready);
            if (tx_start) begin
                starts++;
                checkOutput("rnd_start_expected", qAll.size() != 0, 1);
                if (qAll.size() != 0) begin
                    item = qAll.pop_front();
                    checkOutput("rnd_item", {grant_id, tx_data}, item);
                end
            end
            if (v0 && req0_ready) begin
                qAll.push_back({1'b0, d0});
                sent0++;
                v0 = 1'b0;
            end
            if (v1 && req1_ready) begin
                qAll.push_back({1'b1, d1});
                sent1++;
                v1 = 1'b0;
            end
            tick();
        end
        checkOutput("rnd_sent0", sent0, 200);
        checkOutput("rnd_sent1", sent1, 200);
        checkOutput("rnd_starts", starts, sent0 + sent1);
        checkOutput("rnd_drained", qAll.size(), 0);
        checkOutput("rnd_double_ready", sawFlag, 0);
        applyStimulus(1'b0, 8'h00, 1'b0, 8'h00);

        // Transmitter never acknowledges the start pulse
        doReset();
        forceBusyLow = 1'b1;
        applyStimulus(1'b1, 8'h11, 1'b0, 8'h00);
        checkOutput("to_rdy0", req0_ready, 1);
        tick();
        applyStimulus(1'b0, 8'h00, 1'b0, 8'h00);
        checkOutput("to_start", tx_start, 1);
        sawFlag = 1'b0;
        for (int k = 1; k <= 14; k++) begin
            tick();
            sawFlag |= timeout_err;
        end
        checkOutput("to_quiet", sawFlag, 0);
        tick();
        applyStimulus(1'b0, 8'h00, 1'b1, 8'h22);
        checkOutput("to_err_early", timeout_err, 0);
        checkOutput("to_rdy1_waiting", req1_ready, 0);
        tick();
`ifdef UART_ARB_TIMEOUT_EN
        checkOutput("to_err_pulse", timeout_err, 1);
        checkOutput("to_rdy1_idle", req1_ready, 1);
        tick();
        applyStimulus(1'b0, 8'h00, 1'b0, 8'h00);
        checkOutput("to_err_cleared", timeout_err, 0);
        checkOutput("to_next_start", tx_start, 1);
        checkOutput("to_next_data", tx_data, 8'h22);
        checkOutput("to_next_grant", grant_id, 1);
`else
        checkOutput("to_err_none", timeout_err, 0);
        checkOutput("to_rdy1_stuck", req1_ready, 0);
        tick(40);
        checkOutput("to_still_stuck", req1_ready, 0);
        checkOutput("to_no_start", tx_start, 0);
        checkOutput("to_err_still_none", timeout_err, 0);
`endif
        forceBusyLow = 1'b0;
        applyStimulus(1'b0, 8'h00, 1'b0, 8'h00);

        // Reset pulse during WAIT_DONE, then a tie after release
        doReset();
        bitPeriod = 2;
        applyStimulus(1'b0, 8'h00, 1'b1, 8'h42);
        checkOutput("mid_rdy1", req1_ready, 1);
        tick();
        applyStimulus(1'b0, 8'h00, 1'b0, 8'h00);
        checkOutput("mid_start", tx_start, 1);
        checkOutput("mid_data", tx_data, 8'h42);
        checkOutput("mid_grant", grant_id, 1);
        tick(2);
        checkOutput("mid_busy", tx_busy, 1);
        rst_n = 1'b0;
        #1;
        checkOutput("mid_rst_data", tx_data, 0);
        checkOutput("mid_rst_grant", grant_id, 0);
        checkOutput("mid_rst_start", tx_start, 0);
        checkOutput("mid_rst_timeout", timeout_err, 0);
        tick(2);
        rst_n = 1'b1;
        tick();
        applyStimulus(1'b1, 8'h5A, 1'b1, 8'hA5);
        checkOutput("post_rst_tie", {req1_ready, req0_ready}, 2'b01);
        tick();
        applyStimulus(1'b0, 8'h00, 1'b0, 8'h00);
        checkOutput("post_rst_start", tx_start, 1);
        checkOutput("post_rst_data", tx_data, 8'h5A);
        checkOutput("post_rst_grant", grant_id, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
